// File: rtl/frame_diff_buf_ctrl_if.sv
// Bus bundle for frame_diff_buf_ctrl.
//   master : frame source / difference datapath side (drives vsync, valid,
//            read request and gap; receives memory controls and status)
//   slave  : frame_diff_buf_ctrl side
// Signals keep the original port names of the controller.
interface frame_diff_buf_ctrl_if #(
  parameter int unsigned ADDR_W = 19
);
  logic [1:0]        frame_gap;
  logic              pre_img_vsync;
  logic              pre_img_valid;
  logic              pre_frame_img_req;
  logic              wr_en;
  logic [1:0]        wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_en;
  logic [1:0]        rd_bank;
  logic [ADDR_W-1:0] rd_addr;
  logic              ref_ready;
  logic              err_size;

  modport master (
    output frame_gap, pre_img_vsync, pre_img_valid, pre_frame_img_req,
    input  wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, ref_ready, err_size
  );

  modport slave (
    input  frame_gap, pre_img_vsync, pre_img_valid, pre_frame_img_req,
    output wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, ref_ready, err_size
  );
endinterface

// File: rtl/frame_diff_buf_ctrl.sv
// Frame store controller for the frame-difference datapath.
// Rotates writes of the incoming frame over a 3-bank memory and serves
// reference reads from the bank holding the frame 1 or 2 frames back.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : frame_diff_buf_ctrl_if.slave (vsync/valid/req/gap in;
//              write/read bank+address+enable, ref_ready, err_size out)
//   err_cnt  : 8-bit saturating count of err_size pulses, present only when
//              FRAME_DIFF_ERR_CNT_EN is defined
module frame_diff_buf_ctrl #(
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned ADDR_W = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_diff_buf_ctrl_if.slave  bus
`ifdef FRAME_DIFF_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int unsigned       PIX_N     = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_N - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_t;

  state_t            state_q, state_d;
  logic              vsync_q, vsync_d;
  logic              pend_q, pend_d;
  logic [1:0]        wr_bank_q, wr_bank_d;
  logic [1:0]        rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_full_q, wr_full_d;   // last address already written
  logic              rd_full_q, rd_full_d;   // last address already read
  logic              ovr_q, ovr_d;
  logic              committed_q, committed_d;
  logic [1:0]        stored_q, stored_d;
  logic              ref_ready_q, ref_ready_d;
  logic              err_size_q, err_size_d;

  logic              rise, fall, active, wr_en, rd_en;
  logic [1:0]        gap_sel, next_bank;
  logic [2:0]        rd_sum;

  always_comb begin
    rise      = bus.pre_img_vsync & ~vsync_q;
    fall      = ~bus.pre_img_vsync & vsync_q;
    active    = (state_q == ACTIVE);
    wr_en     = bus.pre_img_valid & active & ~wr_full_q;
    rd_en     = bus.pre_frame_img_req & active & ref_ready_q & ~rd_full_q;
    gap_sel   = (bus.frame_gap == 2'd2) ? 2'd2 : 2'd1;
    next_bank = committed_q ? ((wr_bank_q == 2'd2) ? 2'd0 : wr_bank_q + 2'd1) : wr_bank_q;
    rd_sum    = {1'b0, next_bank} + 3'd3 - {1'b0, gap_sel};

    state_d     = state_q;
    vsync_d     = bus.pre_img_vsync;
    pend_d      = pend_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_full_d   = wr_full_q;
    rd_full_d   = rd_full_q;
    ovr_d       = ovr_q;
    committed_d = committed_q;
    stored_d    = stored_q;
    ref_ready_d = ref_ready_q;
    err_size_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise || pend_q) begin
          state_d     = ACTIVE;
          pend_d      = 1'b0;
          wr_bank_d   = next_bank;
          rd_bank_d   = (rd_sum >= 3'd3) ? 2'(rd_sum - 3'd3) : rd_sum[1:0];
          ref_ready_d = (stored_q >= gap_sel);
          wr_addr_d   = '0;
          rd_addr_d   = '0;
          wr_full_d   = 1'b0;
          rd_full_d   = 1'b0;
          ovr_d       = 1'b0;
        end
      end
      ACTIVE: begin
        // Full flag stands in for "count reached IMG_W*IMG_H" while the
        // address itself saturates at the last pixel.
        if (wr_en) begin
          if (wr_addr_q == LAST_ADDR) wr_full_d = 1'b1;
          else                        wr_addr_d = wr_addr_q + 1'b1;
        end
        if (bus.pre_img_valid && wr_full_q) ovr_d = 1'b1;
        if (rd_en) begin
          if (rd_addr_q == LAST_ADDR) rd_full_d = 1'b1;
          else                        rd_addr_d = rd_addr_q + 1'b1;
        end
        if (fall) state_d = CHECK;
      end
      CHECK: begin
        state_d = IDLE;
        pend_d  = rise;
        if (wr_full_q && !ovr_q) begin
          committed_d = 1'b1;
          stored_d    = (stored_q == 2'd2) ? 2'd2 : stored_q + 2'd1;
        end else begin
          committed_d = 1'b0;
          err_size_d  = 1'b1;
          stored_d    = 2'd0;
          ref_ready_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FRAME_DIFF_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_size_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end
  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      // Reset high so a vsync already high at reset release is not taken
      // as a frame start; the rest of that frame is ignored.
      vsync_q     <= 1'b1;
      pend_q      <= 1'b0;
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_full_q   <= 1'b0;
      rd_full_q   <= 1'b0;
      ovr_q       <= 1'b0;
      committed_q <= 1'b0;
      stored_q    <= '0;
      ref_ready_q <= 1'b0;
      err_size_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync_d;
      pend_q      <= pend_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_full_q   <= wr_full_d;
      rd_full_q   <= rd_full_d;
      ovr_q       <= ovr_d;
      committed_q <= committed_d;
      stored_q    <= stored_d;
      ref_ready_q <= ref_ready_d;
      err_size_q  <= err_size_d;
    end
  end

  always_comb begin
    bus.wr_en     = wr_en;
    bus.wr_bank   = wr_bank_q;
    bus.wr_addr   = wr_addr_q;
    bus.rd_en     = rd_en;
    bus.rd_bank   = rd_bank_q;
    bus.rd_addr   = rd_addr_q;
    bus.ref_ready = ref_ready_q;
    bus.err_size  = err_size_q;
  end

endmodule
